// File: rtl/lime_control_v2_if.sv
// Control bundle between the lime_control_v2 sequencer (master) and the
// fetch/memory, data and calculation blocks (slave).
interface lime_control_v2_if #(
  parameter int OPC_W   = 7,
  parameter int ALUOP_W = 4,
  parameter int CNT_W   = 16
);
  logic [OPC_W-1:0]   input_control;
  logic               input_mem_ready;
  logic [ALUOP_W-1:0] output_control_ALUOp;
  logic [1:0]         output_control_ALUSrcA;
  logic [1:0]         output_control_ALUSrcB;
  logic               output_control_Branch;
  logic               output_control_Decoding;
  logic               output_control_IRWrite;
  logic               output_control_IoD;
  logic               output_control_Mem2Reg;
  logic               output_control_MemR;
  logic               output_control_MemW;
  logic               output_control_PCSrc;
  logic               output_control_PCWrite;
  logic               output_control_RegWrite;
  logic [1:0]         output_control_BranchType;
  logic [3:0]         output_control_current_state;
  logic [3:0]         output_control_next_state;
  logic               output_fault;
  logic               output_halted;
  logic [CNT_W-1:0]   output_instr_count;

  modport master (
    input  input_control, input_mem_ready,
    output output_control_ALUOp, output_control_ALUSrcA, output_control_ALUSrcB,
    output output_control_Branch, output_control_Decoding, output_control_IRWrite,
    output output_control_IoD, output_control_Mem2Reg, output_control_MemR,
    output output_control_MemW, output_control_PCSrc, output_control_PCWrite,
    output output_control_RegWrite, output_control_BranchType,
    output output_control_current_state, output_control_next_state,
    output output_fault, output_halted, output_instr_count
  );

  modport slave (
    output input_control, input_mem_ready,
    input  output_control_ALUOp, output_control_ALUSrcA, output_control_ALUSrcB,
    input  output_control_Branch, output_control_Decoding, output_control_IRWrite,
    input  output_control_IoD, output_control_Mem2Reg, output_control_MemR,
    input  output_control_MemW, output_control_PCSrc, output_control_PCWrite,
    input  output_control_RegWrite, output_control_BranchType,
    input  output_control_current_state, output_control_next_state,
    input  output_fault, output_halted, output_instr_count
  );
endinterface

// File: rtl/lime_control_v2.sv
// Multi-cycle control sequencer: decodes the IR opcode class into datapath
// strobes, with memory wait states, a wait-timeout fault and a retire counter.
module lime_control_v2 #(
  parameter int OPC_W    = 7,
  parameter int ALUOP_W  = 4,
  parameter int MAX_WAIT = 8,
  parameter int CNT_W    = 16
) (
  input  logic               CLK,
  input  logic               Reset,
  lime_control_v2_if.master  bus
);
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_WB_ALU   = 4'd4,
    S_MEM_ADDR = 4'd5,
    S_MEM_RD   = 4'd6,
    S_MEM_WB   = 4'd7,
    S_MEM_WR   = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10,
    S_HALT     = 4'd11,
    S_FAULT    = 4'd12
  } state_t;

  state_t              r_state;
  state_t              w_next;
  state_t              w_moore_sel;
  logic [WAIT_W-1:0]   r_wait;
  logic [CNT_W-1:0]    r_count;
  logic [2:0]          w_cls;
  logic                w_ready;
  logic                w_waiting;
  logic                w_timeout;
  logic                w_run;

  logic [ALUOP_W-1:0]  r_aluop;
  logic [1:0]          r_srca;
  logic [1:0]          r_srcb;
  logic [1:0]          r_btype;
  logic                r_branch;
  logic                r_decoding;
  logic                r_iod;
  logic                r_mem2reg;
  logic                r_memr;
  logic                r_pcsrc;
  logic                r_pcwrite;
  logic                r_regwrite;

  assign w_cls     = bus.input_control[OPC_W-1 -: 3];
  assign w_ready   = bus.input_mem_ready;
  assign w_waiting = ((r_state == S_FETCH) || (r_state == S_MEM_RD) || (r_state == S_MEM_WR))
                     && !w_ready;
  assign w_timeout = w_waiting && (r_wait == WAIT_W'(MAX_WAIT));
  assign w_run     = !Reset;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:    w_next = w_ready ? S_DECODE : (w_timeout ? S_FAULT : S_FETCH);
      S_DECODE: begin
        case (w_cls)
          3'b000:  w_next = S_EXEC_R;
          3'b001:  w_next = S_EXEC_I;
          3'b010,
          3'b011:  w_next = S_MEM_ADDR;
          3'b100:  w_next = S_BRANCH;
          3'b101:  w_next = S_JUMP;
          3'b111:  w_next = S_HALT;
          default: w_next = S_FETCH;
        endcase
      end
      S_EXEC_R,
      S_EXEC_I:   w_next = S_WB_ALU;
      S_WB_ALU:   w_next = S_FETCH;
      S_MEM_ADDR: w_next = w_cls[0] ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   w_next = w_ready ? S_MEM_WB : (w_timeout ? S_FAULT : S_MEM_RD);
      S_MEM_WB:   w_next = S_FETCH;
      S_MEM_WR:   w_next = w_ready ? S_FETCH : (w_timeout ? S_FAULT : S_MEM_WR);
      S_BRANCH,
      S_JUMP:     w_next = S_FETCH;
      S_HALT:     w_next = S_HALT;
      S_FAULT:    w_next = S_FAULT;
      default:    w_next = S_FETCH;
    endcase
  end

  // Moore strobes are registered from the state being entered, so they are
  // valid from the first cycle of that state; reset loads the FETCH set.
  assign w_moore_sel = Reset ? S_FETCH : w_next;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_state <= S_FETCH;
      r_wait  <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_next;
      r_wait  <= (w_waiting && (w_next == r_state)) ? r_wait + 1'b1 : '0;
      if ((w_next == S_FETCH) && (r_state != S_FETCH))
        r_count <= r_count + 1'b1;
    end

    r_aluop    <= '0;
    r_srca     <= 2'b00;
    r_srcb     <= 2'b00;
    r_btype    <= 2'b00;
    r_branch   <= 1'b0;
    r_decoding <= 1'b0;
    r_iod      <= 1'b0;
    r_mem2reg  <= 1'b0;
    r_memr     <= 1'b0;
    r_pcsrc    <= 1'b0;
    r_pcwrite  <= 1'b0;
    r_regwrite <= 1'b0;
    case (w_moore_sel)
      S_FETCH:    begin r_memr <= 1'b1; r_srcb <= 2'b01; end
      S_DECODE:   begin r_decoding <= 1'b1; r_srcb <= 2'b10; end
      S_EXEC_R:   begin r_srca <= 2'b01; r_aluop <= bus.input_control[ALUOP_W-1:0]; end
      S_EXEC_I: begin
        r_srca  <= 2'b01;
        r_srcb  <= 2'b10;
        r_aluop <= bus.input_control[ALUOP_W-1:0];
      end
      S_WB_ALU:   r_regwrite <= 1'b1;
      S_MEM_ADDR: begin r_srca <= 2'b01; r_srcb <= 2'b10; end
      S_MEM_RD:   begin r_memr <= 1'b1; r_iod <= 1'b1; end
      S_MEM_WB:   begin r_regwrite <= 1'b1; r_mem2reg <= 1'b1; end
      S_MEM_WR:   r_iod <= 1'b1;
      S_BRANCH: begin
        r_srca   <= 2'b01;
        r_aluop  <= ALUOP_W'(1);
        r_branch <= 1'b1;
        r_btype  <= bus.input_control[1:0];
        r_pcsrc  <= 1'b1;
      end
      S_JUMP:     begin r_pcwrite <= 1'b1; r_pcsrc <= 1'b1; end
      default:    ;
    endcase
  end

  assign bus.output_control_ALUOp      = w_run ? r_aluop : '0;
  assign bus.output_control_ALUSrcA    = w_run ? r_srca : 2'b00;
  assign bus.output_control_ALUSrcB    = w_run ? r_srcb : 2'b00;
  assign bus.output_control_BranchType = w_run ? r_btype : 2'b00;
  assign bus.output_control_Branch     = w_run && r_branch;
  assign bus.output_control_Decoding   = w_run && r_decoding;
  assign bus.output_control_IoD        = w_run && r_iod;
  assign bus.output_control_Mem2Reg    = w_run && r_mem2reg;
  assign bus.output_control_MemR       = w_run && r_memr;
  assign bus.output_control_PCSrc      = w_run && r_pcsrc;
  assign bus.output_control_RegWrite   = w_run && r_regwrite;
  // Mealy strobes: the access completes in the same cycle ready is seen.
  assign bus.output_control_IRWrite    = w_run && (r_state == S_FETCH) && w_ready;
  assign bus.output_control_PCWrite    = w_run && (r_pcwrite || ((r_state == S_FETCH) && w_ready));
  assign bus.output_control_MemW       = w_run && (r_state == S_MEM_WR) && w_ready;

  assign bus.output_control_current_state = w_run ? r_state : 4'd0;
  assign bus.output_control_next_state    = w_run ? w_next : 4'd0;
  assign bus.output_fault                 = w_run && (r_state == S_FAULT);
  assign bus.output_halted                = w_run && (r_state == S_HALT);
  assign bus.output_instr_count           = r_count;
endmodule

// File: doc/lime_control_v2.md
# lime_control_v2

Parametrised multi-cycle control sequencer for the 16-bit multi-cycle processor. It replaces the fixed-latency control FSM with one that adds:
- configurable opcode and ALU-op widths
- a memory ready handshake with wait states
- a wait-timeout fault state
- a retired-instruction counter

It sits beside the fetch/memory, data and calculations blocks and drives all of their control strobes from the IR opcode field.

## Interface
- OPC_W, 7, opcode width; must be ≥ 7
- ALUOP_W, 4, ALU operation width
- MAX_WAIT, 8, longest allowed consecutive memory wait cycles before fault; must be ≥ 1
- CNT_W, 16, retired-instruction counter width
- CLK  in  1  clock; all state changes on the rising edge
- Reset  in  1  synchronous, active-high reset
- input_control  in  OPC_W  opcode from IR
- input_mem_ready  in  1  memory completes the current access this cycle
- output_control_ALUOp  out  ALUOP_W
- output_control_ALUSrcA, output_control_ALUSrcB  out  2 each  (A: 00 PC, 01 regA; B: 00 regB, 01 const 2, 10 imm)
- output_control_Branch, output_control_Decoding, output_control_IRWrite, output_control_IoD, output_control_Mem2Reg, output_control_MemR, output_control_MemW, output_control_PCSrc, output_control_PCWrite, output_control_RegWrite  out  1 each
- output_control_BranchType  out  2
- output_control_current_state, output_control_next_state  out  4
- output_fault  out  1  sticky memory-timeout flag
- output_halted  out  1  high in HALT
- output_instr_count  out  CNT_W  retired instructions

## Operation
- Class field is `cls = input_control[OPC_W-1 -: 3]`:
  - 000 R-ALU, 001 I-ALU, 010 load, 011 store, 100 branch, 101 jump, 110 reserved (treated as NOP), 111 halt.
- ALU classes use `ALUOp = input_control[ALUOP_W-1:0]`. ADD = 0, SUB = 1.
- State encoding: FETCH 0, DECODE 1, EXEC_R 2, EXEC_I 3, WB_ALU 4, MEM_ADDR 5, MEM_RD 6, MEM_WB 7, MEM_WR 8, BRANCH 9, JUMP 10, HALT 11, FAULT 12.
- Any strobe not listed for a state is 0. ALUSrc fields default to 00 and ALUOp to ADD.
- FETCH:
  - MemR=1, IoD=0, ALUSrcA=00, ALUSrcB=01.
  - IRWrite=PCWrite=input_mem_ready (Mealy).
  - Ready → DECODE; not ready → stay.
- DECODE: Decoding=1, ALUSrcA=00, ALUSrcB=10. Next state by class:
  - R → EXEC_R
  - I → EXEC_I
  - load/store → MEM_ADDR
  - branch → BRANCH
  - jump → JUMP
  - halt → HALT
  - reserved → FETCH, which retires the instruction.
- EXEC_R: ALUSrcA=01, ALUSrcB=00, ALUOp from opcode → WB_ALU.
- EXEC_I: ALUSrcA=01, ALUSrcB=10, ALUOp from opcode → WB_ALU.
- WB_ALU: RegWrite=1, Mem2Reg=0 → FETCH.
- MEM_ADDR: ALUSrcA=01, ALUSrcB=10, ADD → MEM_RD (load) or MEM_WR (store).
- MEM_RD: MemR=1, IoD=1. Ready → MEM_WB; not ready → stay.
- MEM_WB: RegWrite=1, Mem2Reg=1 → FETCH.
- MEM_WR:
  - MemR=0, IoD=1.
  - MemW=input_mem_ready (Mealy), so exactly one write strobe is issued.
  - Ready → FETCH; not ready → stay.
- BRANCH: ALUSrcA=01, ALUSrcB=00, SUB, Branch=1, BranchType=input_control[1:0], PCSrc=1 → FETCH. Taken/not-taken is resolved downstream.
- JUMP: PCWrite=1, PCSrc=1 → FETCH.
- HALT: all strobes 0, output_halted=1. Stays until Reset.
- FAULT: all strobes 0, output_fault=1. Stays until Reset.
- Wait counter (width $clog2(MAX_WAIT+1)):
  - Increments each cycle spent in FETCH, MEM_RD or MEM_WR with input_mem_ready=0.
  - Clears on ready or on any state change.
  - If the counter equals MAX_WAIT while ready is still 0, next state is FAULT instead of staying.
- output_instr_count increments by 1 on every transition into FETCH from any state other than FETCH. It wraps modulo 2^CNT_W and does not count HALT or FAULT.

## Timing
- Reset has priority over everything. On the edge with Reset=1:
  - state ← FETCH, wait counter ← 0, instr_count ← 0.
  - While Reset is high, all strobes are 0 (including the Mealy ones), output_fault=0, output_halted=0, current_state=next_state=0.
- Reset mid-access abandons the access. No MemW is issued in the reset cycle.
- Moore outputs are valid from the cycle the state is entered. Mealy strobes follow input_mem_ready combinationally in the same cycle.
- output_control_next_state is combinational and equals the value current_state takes at the next edge.
- Zero-wait instruction latencies:
  - R/I-ALU: 4 cycles.
  - Load: 5 cycles.
  - Store, branch, jump, NOP: 4, 3, 3 and 2 cycles.
  - Each wait cycle in FETCH, MEM_RD or MEM_WR adds 1.
- Fault timing: a memory holding ready=0 enters FAULT after exactly MAX_WAIT+1 cycles in the waiting state. Ready=1 on that last cycle completes normally.

## Test plan
- Reset held 3 cycles, then released with ready=1 and opcode 7'b000_0000 → state sequence 0,1,2,4,0. RegWrite=1 only in state 4. instr_count=1 after 4 cycles.
- Load (7'b010_0000) with ready=0 for 2 cycles in MEM_RD → MEM_RD lasts 3 cycles, Mem2Reg=RegWrite=1 one cycle later. Total 7 cycles.
- Store (7'b011_0000) with ready low for 1 cycle → MemW low in the wait cycle and high for exactly 1 cycle on ready.
- Ready held 0 in FETCH, MAX_WAIT=8 → current_state=12 after 9 cycles and output_fault=1 until Reset. Repeat with ready rising on the 9th cycle → DECODE and no fault.
- Branch opcode 7'b100_0010 → BRANCH with Branch=1, BranchType=2'b10, ALUOp=1, PCSrc=1. Halt opcode → state 11 held for 20 cycles, instr_count frozen.
- CNT_W=4: run 17 NOPs → instr_count=1 (wrap). Assert Reset during MEM_WR → no MemW, state 0 on the next cycle.
